dual_issue_scheduler: RTL and testbench

- Sits between the IF stage and the two-lane IF/ID pipeline registers.
- Buffers one fetched instruction pair and decides each cycle whether to issue both, lane 1 only, or a bubble.
- Issue is decided by intra-pair dependencies, resource conflicts and load-use hazards against EX.
- Guarantees the MEM-stage branch forwarding unit only ever sees pairs it can resolve; flushes on a taken branch resolved in MEM.

---
 rtl/dual_issue_scheduler_pkg.sv | 37 +++
 rtl/dual_issue_scheduler_decode.sv | 75 +++++++
 rtl/dual_issue_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared opcode constants, FSM encoding and decoded-instruction bundle
// for the dual-issue scheduler.
package dual_issue_scheduler_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAIR = 2'd1,
        LEFT = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       reads_rs;
        logic       reads_rt;
        logic       is_mem;
        logic       is_ctrl;
        logic       is_jump;
    } dec_t;

    // Register 0 is hardwired, so a read of it never creates a dependency.
    function automatic logic reads_reg(dec_t d, logic [4:0] r);
        return (r != 5'd0) &&
               ((d.reads_rs && d.rs == r) || (d.reads_rt && d.rt == r));
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_decode.sv
// Per-slot register usage and instruction class decode.
module issue_decode
    import dual_issue_scheduler_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dest,
    output logic        reads_rs,
    output logic        reads_rt,
    output logic        is_mem,
    output logic        is_ctrl,
    output logic        is_jump
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_shamt;

    assign op           = inst[31:26];
    assign funct        = inst[5:0];
    assign rs           = inst[25:21];
    assign rt           = inst[20:16];
    assign unused_shamt = ^inst[10:6];

    always_comb begin
        dest     = 5'd0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        is_mem   = 1'b0;
        is_ctrl  = 1'b0;
        is_jump  = 1'b0;
        case (op)
            OP_RTYPE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                if (funct == FUNCT_JR) begin
                    is_ctrl = 1'b1;
                    is_jump = 1'b1;
                end else begin
                    dest = inst[15:11];
                end
            end
            OP_LW: begin
                reads_rs = 1'b1;
                dest     = rt;
                is_mem   = 1'b1;
            end
            OP_SW: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                is_mem   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                is_ctrl  = 1'b1;
            end
            OP_J: begin
                is_ctrl = 1'b1;
                is_jump = 1'b1;
            end
            OP_JAL: begin
                is_ctrl = 1'b1;
                is_jump = 1'b1;
                dest    = 5'd31;
            end
            default: begin
                reads_rs = 1'b1;
                dest     = rt;
            end
        endcase
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-slot instruction buffer deciding dual, single or no issue per cycle
// from intra-pair dependencies, resource conflicts and EX load-use hazards.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_inst1,
    input  logic [31:0]      fetch_inst2,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_ready,
    input  logic             ex_memread_1,
    input  logic             ex_memread_2,
    input  logic [4:0]       ex_dest_1,
    input  logic [4:0]       ex_dest_2,
    input  logic             hold,
    input  logic             flush,
    output logic             issue_valid1,
    output logic             issue_valid2,
    output logic [31:0]      issue_inst1,
    output logic [31:0]      issue_inst2,
    output logic [31:0]      issue_pc1,
    output logic [31:0]      issue_pc2,
    output logic [CNT_W-1:0] cnt_dual,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_stall
);

    state_t      state, state_nx;
    logic [31:0] inst_a, inst_b, pc_a, pc_b;
    dec_t        dec_a, dec_b;
    logic        luse_a, luse_b, pair_ok, stall_pair, stall_left;
    logic        load, inc_dual, inc_single, inc_stall;
    logic        unused_dec;

    issue_decode u_dec_a (
        .inst(inst_a), .rs(dec_a.rs), .rt(dec_a.rt), .dest(dec_a.dest),
        .reads_rs(dec_a.reads_rs), .reads_rt(dec_a.reads_rt),
        .is_mem(dec_a.is_mem), .is_ctrl(dec_a.is_ctrl),
        .is_jump(dec_a.is_jump)
    );

    issue_decode u_dec_b (
        .inst(inst_b), .rs(dec_b.rs), .rt(dec_b.rt), .dest(dec_b.dest),
        .reads_rs(dec_b.reads_rs), .reads_rt(dec_b.reads_rt),
        .is_mem(dec_b.is_mem), .is_ctrl(dec_b.is_ctrl),
        .is_jump(dec_b.is_jump)
    );

    assign unused_dec = dec_b.is_jump;
    assign pc_b       = pc_a + 32'd4;

    assign luse_a = (ex_memread_1 && reads_reg(dec_a, ex_dest_1)) ||
                    (ex_memread_2 && reads_reg(dec_a, ex_dest_2));
    assign luse_b = (ex_memread_1 && reads_reg(dec_b, ex_dest_1)) ||
                    (ex_memread_2 && reads_reg(dec_b, ex_dest_2));

    assign pair_ok = !reads_reg(dec_b, dec_a.dest) &&
                     !(dec_a.dest != 5'd0 && dec_a.dest == dec_b.dest) &&
                     !(dec_a.is_mem && dec_b.is_mem) &&
                     !(dec_a.is_ctrl && dec_b.is_ctrl) &&
                     !dec_a.is_jump;

    // B only counts toward the hazard when it would actually go out with A.
    assign stall_pair = hold || luse_a || (pair_ok && luse_b);
    assign stall_left = hold || luse_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = fetch_valid ? PAIR : IDLE;
                PAIR: begin
                    if (!stall_pair) begin
                        if (pair_ok) state_nx = fetch_valid ? PAIR : IDLE;
                        else         state_nx = LEFT;
                    end
                end
                LEFT: begin
                    if (!stall_left) state_nx = fetch_valid ? PAIR : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_ready  = 1'b0;
        issue_valid1 = 1'b0;
        issue_valid2 = 1'b0;
        issue_inst1  = '0;
        issue_inst2  = '0;
        issue_pc1    = '0;
        issue_pc2    = '0;
        load         = 1'b0;
        inc_dual     = 1'b0;
        inc_single   = 1'b0;
        inc_stall    = 1'b0;
        if (flush) begin
            fetch_ready = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    fetch_ready = 1'b1;
                    load        = fetch_valid;
                end
                PAIR: begin
                    if (stall_pair) begin
                        inc_stall = 1'b1;
                    end else begin
                        issue_valid1 = 1'b1;
                        issue_inst1  = inst_a;
                        issue_pc1    = pc_a;
                        if (pair_ok) begin
                            issue_valid2 = 1'b1;
                            issue_inst2  = inst_b;
                            issue_pc2    = pc_b;
                            inc_dual     = 1'b1;
                            fetch_ready  = 1'b1;
                            load         = fetch_valid;
                        end else begin
                            inc_single = 1'b1;
                        end
                    end
                end
                LEFT: begin
                    if (stall_left) begin
                        inc_stall = 1'b1;
                    end else begin
                        issue_valid1 = 1'b1;
                        issue_inst1  = inst_b;
                        issue_pc1    = pc_b;
                        inc_single   = 1'b1;
                        fetch_ready  = 1'b1;
                        load         = fetch_valid;
                    end
                end
                default: fetch_ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_a <= '0;
            inst_b <= '0;
            pc_a   <= '0;
        end else if (load) begin
            inst_a <= fetch_inst1;
            inst_b <= fetch_inst2;
            pc_a   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_dual   <= '0;
            cnt_single <= '0;
            cnt_stall  <= '0;
        end else begin
            if (inc_dual && cnt_dual != '1)     cnt_dual   <= cnt_dual + 1'b1;
            if (inc_single && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
            if (inc_stall && cnt_stall != '1)   cnt_stall  <= cnt_stall + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench: stimulus queues expected issues, a monitor checks them.
module tb_dual_issue_scheduler;

    localparam int CNT_W = 16;
    localparam int NSAT  = (1 << CNT_W) + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_valid;
    logic [31:0]      fetch_inst1, fetch_inst2, fetch_pc;
    logic             fetch_ready;
    logic             ex_memread_1, ex_memread_2;
    logic [4:0]       ex_dest_1, ex_dest_2;
    logic             hold, flush;
    logic             issue_valid1, issue_valid2;
    logic [31:0]      issue_inst1, issue_inst2, issue_pc1, issue_pc2;
    logic [CNT_W-1:0] cnt_dual, cnt_single, cnt_stall;

    typedef struct packed {
        logic        v2;
        logic [31:0] inst1;
        logic [31:0] pc1;
        logic [31:0] inst2;
        logic [31:0] pc2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_inst1(fetch_inst1),
        .fetch_inst2(fetch_inst2), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .ex_memread_1(ex_memread_1), .ex_memread_2(ex_memread_2),
        .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
        .hold(hold), .flush(flush),
        .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
        .issue_inst1(issue_inst1), .issue_inst2(issue_inst2),
        .issue_pc1(issue_pc1), .issue_pc2(issue_pc2),
        .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push(logic v2, logic [31:0] i1, logic [31:0] p1,
                        logic [31:0] i2, logic [31:0] p2);
        exp_t e;
        e.v2 = v2; e.inst1 = i1; e.pc1 = p1; e.inst2 = i2; e.pc2 = p2;
        q.push_back(e);
    endtask

    // Offer a pair while the scheduler is expected to be IDLE.
    task automatic load(logic [31:0] i1, logic [31:0] i2, logic [31:0] pc);
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_inst1 = i1;
        fetch_inst2 = i2;
        fetch_pc    = pc;
        #1;
        chk("idle_ready", 64'(fetch_ready), 64'd1);
    endtask

    task automatic split(logic [31:0] i1, logic [31:0] i2, logic [31:0] pc);
        load(i1, i2, pc);
        @(negedge clk);
        fetch_valid = 1'b0;
        push(1'b0, i1, pc, '0, '0);
        #1;
        chk("single_a_ready", 64'(fetch_ready), 64'd0);
        @(negedge clk);
        push(1'b0, i2, pc + 32'd4, '0, '0);
        #1;
        chk("single_b_ready", 64'(fetch_ready), 64'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (issue_valid1 || issue_valid2) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_issue: got v1=%0b v2=%0b pc1=%0h expected none",
                             issue_valid1, issue_valid2, issue_pc1);
                end else begin
                    e = q.pop_front();
                    if (issue_valid1 === 1'b1 && issue_valid2 === e.v2 &&
                        issue_inst1 === e.inst1 && issue_pc1 === e.pc1 &&
                        (!e.v2 || (issue_inst2 === e.inst2 && issue_pc2 === e.pc2)))
                        passed++;
                    else
                        $display("FAIL issue: got v=%0b%0b %0h@%0h %0h@%0h expected v=1%0b %0h@%0h %0h@%0h",
                                 issue_valid1, issue_valid2, issue_inst1, issue_pc1,
                                 issue_inst2, issue_pc2, e.v2, e.inst1, e.pc1,
                                 e.inst2, e.pc2);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] add3, add6, sub4, adda, addb;
        add3 = rtype(1, 2, 3, 32'h20);
        add6 = rtype(4, 5, 6, 32'h20);
        sub4 = rtype(3, 1, 4, 32'h22);
        adda = rtype(5, 1, 6, 32'h20);
        addb = rtype(2, 3, 7, 32'h20);

        rst = 1'b1; fetch_valid = 1'b0; fetch_inst1 = '0; fetch_inst2 = '0;
        fetch_pc = '0; ex_memread_1 = 1'b0; ex_memread_2 = 1'b0;
        ex_dest_1 = '0; ex_dest_2 = '0; hold = 1'b0; flush = 1'b0;
        #3;
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_valid", 64'({issue_valid1, issue_valid2}), 64'd0);
        chk("rst_cnt", 64'({cnt_dual, cnt_single, cnt_stall}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Independent pair
        load(add3, add6, 32'h100);
        @(negedge clk);
        fetch_valid = 1'b0;
        push(1'b1, add3, 32'h100, add6, 32'h104);
        @(negedge clk);
        #1;
        chk("dual_cnt", 64'(cnt_dual), 64'd1);

        // RAW inside the pair
        split(add3, sub4, 32'h200);
        @(negedge clk);
        #1;
        chk("raw_cnt", 64'(cnt_single), 64'd2);

        // Load-use against EX lane 1, then an external hold
        load(adda, addb, 32'h300);
        @(negedge clk);
        fetch_valid = 1'b0;
        ex_memread_1 = 1'b1;
        ex_dest_1 = 5'd5;
        #1;
        chk("luse_noissue", 64'({issue_valid1, issue_valid2, fetch_ready}), 64'd0);
        @(negedge clk);
        ex_memread_1 = 1'b0;
        ex_dest_1 = 5'd0;
        hold = 1'b1;
        #1;
        chk("hold_noissue", 64'(issue_valid1), 64'd0);
        @(negedge clk);
        hold = 1'b0;
        push(1'b1, adda, 32'h300, addb, 32'h304);
        @(negedge clk);
        #1;
        chk("stall_cnt", 64'(cnt_stall), 64'd2);
        chk("dual_cnt2", 64'(cnt_dual), 64'd2);

        // Resource conflicts: mem/mem, ctrl/ctrl, jump in A
        split(itype(32'h23, 1, 8, 0), itype(32'h2B, 2, 9, 4), 32'h400);
        split(itype(32'h04, 1, 2, 3), itype(32'h05, 3, 4, 5), 32'h410);
        split({6'h02, 26'h40}, add3, 32'h420);
        @(negedge clk);
        #1;
        chk("conflict_cnt", 64'(cnt_single), 64'd8);

        // Flush while LEFT with a pair on offer
        load(add3, sub4, 32'h500);
        @(negedge clk);
        fetch_valid = 1'b0;
        push(1'b0, add3, 32'h500, '0, '0);
        @(negedge clk);
        flush = 1'b1;
        fetch_valid = 1'b1;
        fetch_inst1 = add3;
        fetch_inst2 = add6;
        fetch_pc = 32'h600;
        #1;
        chk("flush_out", 64'({issue_valid1, issue_valid2, fetch_ready}), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("flush_idle", 64'({issue_valid1, fetch_ready}), 64'd1);
        chk("flush_cnt", 64'({cnt_dual, cnt_single, cnt_stall}),
            64'({16'd2, 16'd9, 16'd2}));

        // Asynchronous reset mid-PAIR
        load(add3, add6, 32'h700);
        @(negedge clk);
        fetch_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out", 64'({issue_valid1, issue_valid2, fetch_ready}), 64'd1);
        chk("arst_cnt", 64'({cnt_dual, cnt_single, cnt_stall}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation of the dual counter
        load(add3, add6, 32'h1000);
        for (int i = 0; i < NSAT; i++) begin
            @(negedge clk);
            push(1'b1, add3, 32'h1000 + 32'(8 * i), add6, 32'h1004 + 32'(8 * i));
            fetch_valid = (i < NSAT - 1);
            fetch_pc = 32'h1000 + 32'(8 * (i + 1));
        end
        @(negedge clk);
        fetch_valid = 1'b0;
        #1;
        chk("sat_dual", 64'(cnt_dual), 64'hFFFF);
        chk("sat_others", 64'({cnt_single, cnt_stall}), 64'd0);

        @(negedge clk);
        #3;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
